// File: rtl/pcs_tx_oset_gen_wide.sv
// rtl/pcs_tx_oset_gen_wide.sv - multi-slot Clause 36 transmit ordered-set generator
module pcs_tx_oset_gen_wide #(
    parameter int LANES      = 1,
    parameter int CFG_REPEAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mr_main_reset,
    input  logic                 tx_ce,
    input  logic [1:0]           xmit,
    input  logic [15:0]          tx_config_reg,
    input  logic [8*LANES-1:0]   TXD,
    input  logic [LANES-1:0]     TX_EN,
    input  logic [LANES-1:0]     TX_ER,
    input  logic                 assert_lpidle,
    input  logic                 receiving,
    input  logic                 tx_rd_pos,
    output logic [9*LANES-1:0]   tx_sym,
    output logic                 tx_sym_valid,
    output logic                 tx_even,
    output logic                 transmitting,
    output logic                 COL,
    output logic [2:0]           tx_state
);

    localparam logic [1:0] XMIT_CONFIG = 2'd0;
    localparam logic [1:0] XMIT_DATA   = 2'd2;

    localparam logic [8:0] SYM_K285 = 9'h1BC;
    localparam logic [8:0] SYM_S    = 9'h1FB;
    localparam logic [8:0] SYM_T    = 9'h1FD;
    localparam logic [8:0] SYM_R    = 9'h1F7;
    localparam logic [8:0] SYM_V    = 9'h1FE;

    localparam logic [7:0] OCT_C1  = 8'hB5;
    localparam logic [7:0] OCT_C2  = 8'h42;
    localparam logic [7:0] OCT_I1  = 8'hC5;
    localparam logic [7:0] OCT_I2  = 8'h50;
    localparam logic [7:0] OCT_LI1 = 8'hA6;
    localparam logic [7:0] OCT_LI2 = 8'h9A;
    localparam logic [7:0] OCT_EXT = 8'h0F;

    localparam logic [3:0] CFG_LAST = 4'(CFG_REPEAT - 1);

    typedef enum logic [2:0] {
        ST_CONFIG = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LPI    = 3'd2,
        ST_DATA   = 3'd3,
        ST_END    = 3'd4,
        ST_ALIGN  = 3'd5
    } state_t;

    // Registered state
    state_t       state_q;
    logic [1:0]   pos_q;
    logic [3:0]   cnt_q;
    logic         phase_q;
    logic [15:0]  cfg_q;
    logic [7:0]   odd_q;
    logic         even_q;
    logic [9:0]   fifo_q [2];

    // Next-state values produced by the slot walk
    state_t       state_n;
    logic [1:0]   pos_n;
    logic [3:0]   cnt_n;
    logic         phase_n;
    logic [15:0]  cfg_n;
    logic [7:0]   odd_n;
    logic         even_n;
    logic [9:0]   fifo_n [2];
    logic [9*LANES-1:0] sym_n;
    logic         busy_n;

    // Slot-walk scratch
    logic [9:0]   cat [LANES+2];
    logic [8:0]   slot_sym;
    logic         slot_busy;
    logic [7:0]   oct;
    logic         en;
    logic         er;
    state_t       post_st;

    assign tx_state = state_q;

    // Walk the LANES slots of this cycle in time order, oldest buffered octet first
    always_comb begin
        cat[0] = fifo_q[0];
        cat[1] = fifo_q[1];
        for (int i = 0; i < LANES; i++) begin
            cat[2+i] = {TX_ER[i], TX_EN[i], TXD[8*i +: 8]};
        end
        state_n   = state_q;
        pos_n     = pos_q;
        cnt_n     = cnt_q;
        phase_n   = phase_q;
        cfg_n     = cfg_q;
        odd_n     = odd_q;
        even_n    = even_q;
        sym_n     = '0;
        busy_n    = 1'b0;
        slot_sym  = SYM_K285;
        slot_busy = 1'b0;
        oct       = 8'h00;
        en        = 1'b0;
        er        = 1'b0;
        post_st   = (xmit == XMIT_CONFIG) ? ST_CONFIG : ST_IDLE;
        for (int i = 0; i < LANES; i++) begin
            oct       = cat[i][7:0];
            en        = cat[i][8];
            er        = cat[i][9];
            slot_sym  = SYM_K285;
            slot_busy = 1'b0;

            // Mode changes out of IDLE/LPI only take effect on an ordered-set boundary
            if ((state_n == ST_IDLE || state_n == ST_LPI) && even_n && xmit == XMIT_CONFIG) begin
                state_n = ST_CONFIG;
                pos_n   = 2'd0;
            end
            if (state_n == ST_LPI && even_n && (!assert_lpidle || en)) begin
                state_n = ST_IDLE;
            end

            case (state_n)
                ST_CONFIG: begin
                    case (pos_n)
                        2'd0: begin
                            slot_sym = SYM_K285;
                            cfg_n    = tx_config_reg;
                        end
                        2'd1: slot_sym = {1'b0, phase_n ? OCT_C2 : OCT_C1};
                        2'd2: slot_sym = {1'b0, cfg_n[7:0]};
                        default: begin
                            slot_sym = {1'b0, cfg_n[15:8]};
                            if (cnt_n == CFG_LAST) begin
                                cnt_n   = 4'd0;
                                phase_n = ~phase_n;
                            end else begin
                                cnt_n = cnt_n + 4'd1;
                            end
                            if (xmit != XMIT_CONFIG) begin
                                state_n = ST_IDLE;
                            end
                        end
                    endcase
                    pos_n = pos_n + 2'd1;
                end
                ST_IDLE: begin
                    if (!even_n) begin
                        slot_sym = {1'b0, odd_n};
                    end else if (xmit == XMIT_DATA && en) begin
                        slot_sym  = SYM_S;
                        slot_busy = 1'b1;
                        state_n   = ST_DATA;
                    end else if (assert_lpidle && !en) begin
                        odd_n   = tx_rd_pos ? OCT_LI1 : OCT_LI2;
                        state_n = ST_LPI;
                    end else begin
                        odd_n = tx_rd_pos ? OCT_I1 : OCT_I2;
                    end
                end
                ST_LPI: begin
                    if (!even_n) begin
                        slot_sym = {1'b0, odd_n};
                    end else begin
                        odd_n = tx_rd_pos ? OCT_LI1 : OCT_LI2;
                    end
                end
                ST_DATA: begin
                    slot_busy = 1'b1;
                    if (en) begin
                        slot_sym = er ? SYM_V : {1'b0, oct};
                    end else begin
                        slot_sym = SYM_T;
                        state_n  = ST_END;
                    end
                end
                ST_END: begin
                    slot_busy = 1'b1;
                    if (er && !en) begin
                        slot_sym = (oct == OCT_EXT) ? SYM_R : SYM_V;
                    end else begin
                        // A trailing /R/ on an even slot needs a second one to realign
                        slot_sym = SYM_R;
                        state_n  = even_n ? ST_ALIGN : post_st;
                        pos_n    = 2'd0;
                    end
                end
                ST_ALIGN: begin
                    slot_busy = 1'b1;
                    slot_sym  = SYM_R;
                    state_n   = post_st;
                    pos_n     = 2'd0;
                end
                default: begin
                    state_n = ST_CONFIG;
                    pos_n   = 2'd0;
                end
            endcase

            sym_n[9*i +: 9] = slot_sym;
            busy_n          = busy_n | slot_busy;
            even_n          = ~even_n;
        end
        fifo_n[0] = cat[LANES];
        fifo_n[1] = cat[LANES+1];
    end

    // State, slot buffer and output registers; both resets force CONFIG and flush the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CONFIG;
            pos_q        <= 2'd0;
            cnt_q        <= 4'd0;
            phase_q      <= 1'b0;
            cfg_q        <= 16'h0000;
            odd_q        <= OCT_I2;
            even_q       <= 1'b1;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            tx_sym       <= {LANES{SYM_K285}};
            tx_sym_valid <= 1'b0;
            tx_even      <= 1'b0;
            transmitting <= 1'b0;
            COL          <= 1'b0;
        end else if (mr_main_reset) begin
            state_q      <= ST_CONFIG;
            pos_q        <= 2'd0;
            cnt_q        <= 4'd0;
            phase_q      <= 1'b0;
            cfg_q        <= 16'h0000;
            odd_q        <= OCT_I2;
            even_q       <= 1'b1;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            tx_sym       <= {LANES{SYM_K285}};
            tx_sym_valid <= 1'b0;
            tx_even      <= 1'b0;
            transmitting <= 1'b0;
            COL          <= 1'b0;
        end else begin
            tx_sym_valid <= tx_ce;
            if (tx_ce) begin
                state_q      <= state_n;
                pos_q        <= pos_n;
                cnt_q        <= cnt_n;
                phase_q      <= phase_n;
                cfg_q        <= cfg_n;
                odd_q        <= odd_n;
                even_q       <= even_n;
                fifo_q[0]    <= fifo_n[0];
                fifo_q[1]    <= fifo_n[1];
                tx_sym       <= sym_n;
                tx_even      <= even_q;
                transmitting <= busy_n;
                COL          <= transmitting & receiving & (xmit == XMIT_DATA);
            end
        end
    end

endmodule
